// File: rtl/pwm_ramp_pkg.sv
// Shared types and constants for the PWM ramp controller and its timebase.
// CTRL bit1 (irq mask) is only meaningful when PWM_RAMP_IRQ_EN is defined.
package pwm_ramp_pkg;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_SCAN = 1'b1
  } state_e;

  localparam int TGT_BASE = 0;

  localparam int EN_BIT   = 0;
  localparam int IRQM_BIT = 1;
  localparam int STEP_LSB = 8;
  localparam int STEP_MSB = 15;

  // CTRL and STATUS sit directly above the per-channel target registers.
  function automatic int ctrl_ofs(input int num_ch);
    return TGT_BASE + num_ch;
  endfunction

  function automatic int stat_ofs(input int num_ch);
    return TGT_BASE + num_ch + 1;
  endfunction

endpackage

// File: rtl/pwm_timebase.sv
// Free-running 0..PERIOD counter with a registered tick in the cycle count==PERIOD.
// Shared between the ramp controller and the PWM cores so all agree on the period.
module pwm_timebase #(
  parameter int PERIOD = 100
) (
  input  logic                             clock,
  input  logic                             reset,
  output logic [$clog2(PERIOD+1)-1:0]      count,
  output logic                             period_tick
);

  localparam int CNT_W = $clog2(PERIOD + 1);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(PERIOD);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             tick_q, tick_d;

  always_comb begin
    cnt_d  = (cnt_q == LAST) ? '0 : cnt_q + CNT_W'(1);
    tick_d = (cnt_d == LAST);
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      cnt_q  <= '0;
      tick_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      tick_q <= tick_d;
    end
  end

  assign count       = cnt_q;
  assign period_tick = tick_q;

endmodule

// File: rtl/pwm_ramp_ctrl.sv
// Register-mapped controller ramping NUM_CH PWM duties toward their targets once per period.
// Define PWM_RAMP_IRQ_EN to add the masked "ramp complete" irq output and CTRL bit1.
module pwm_ramp_ctrl
  import pwm_ramp_pkg::*;
#(
  parameter int NUM_CH = 4,
  parameter int PERIOD = 100,
  parameter int DUTY_W = 32,
  parameter int ADDR_W = 5
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     wr_en,
  input  logic [ADDR_W-1:0]        wr_addr,
  input  logic [DUTY_W-1:0]        wr_data,
  input  logic [ADDR_W-1:0]        rd_addr,
  output logic [DUTY_W-1:0]        rd_data,
  output logic [NUM_CH*DUTY_W-1:0] duty_out,
  output logic [NUM_CH-1:0]        duty_upd,
  output logic                     period_tick,
  output logic                     busy
`ifdef PWM_RAMP_IRQ_EN
  ,
  output logic                     irq
`endif
);

  localparam int IDX_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(NUM_CH - 1);
  localparam logic [ADDR_W-1:0] CTRL_A   = ADDR_W'(ctrl_ofs(NUM_CH));
  localparam logic [ADDR_W-1:0] STAT_A   = ADDR_W'(stat_ofs(NUM_CH));
  localparam logic [DUTY_W-1:0] MAX_DUTY = DUTY_W'(PERIOD);

  logic [NUM_CH-1:0][DUTY_W-1:0] tgt_q, tgt_d;
  logic [NUM_CH-1:0][DUTY_W-1:0] live_q, live_d;
  logic [NUM_CH-1:0]             upd_q, upd_d;
  logic [NUM_CH-1:0]             status;
  state_e                        state_q, state_d;
  logic [IDX_W-1:0]              idx_q, idx_d;
  logic                          en_q, en_d;
  logic [7:0]                    step_q, step_d;
  logic                          ctrl_wr;
  logic [$clog2(PERIOD+1)-1:0]   tb_cnt_unused;

  function automatic logic [DUTY_W-1:0] clamp_duty(input logic [DUTY_W-1:0] v);
    return (v > MAX_DUTY) ? MAX_DUTY : v;
  endfunction

  // Widened by one bit so live+step can never wrap past the target.
  function automatic logic [DUTY_W-1:0] ramp_step(input logic [DUTY_W-1:0] live,
                                                  input logic [DUTY_W-1:0] tgt,
                                                  input logic [7:0]        step);
    logic [DUTY_W:0] live_x, tgt_x, step_x, sum_x;
    live_x = {1'b0, live};
    tgt_x  = {1'b0, tgt};
    step_x = (DUTY_W+1)'(step);
    sum_x  = live_x + step_x;
    if (step == 8'd0)        return tgt;
    else if (live_x < tgt_x) return (sum_x >= tgt_x) ? tgt : sum_x[DUTY_W-1:0];
    else if (live_x > tgt_x) return (live_x >= tgt_x + step_x) ? live - DUTY_W'(step) : tgt;
    else                     return live;
  endfunction

  pwm_timebase #(.PERIOD(PERIOD)) u_timebase (
    .clock       (clock),
    .reset       (reset),
    .count       (tb_cnt_unused),
    .period_tick (period_tick)
  );

  assign ctrl_wr = wr_en && (wr_addr == CTRL_A);

  always_comb begin
    tgt_d  = tgt_q;
    en_d   = en_q;
    step_d = step_q;
    if (ctrl_wr) begin
      en_d   = wr_data[EN_BIT];
      step_d = wr_data[STEP_MSB:STEP_LSB];
    end
    for (int i = 0; i < NUM_CH; i++) begin
      if (wr_en && (wr_addr == ADDR_W'(TGT_BASE + i))) tgt_d[i] = clamp_duty(wr_data);
    end
  end

  // Scan reads the registered target, so a same-cycle write only affects later scans.
  always_comb begin
    live_d  = live_q;
    upd_d   = '0;
    state_d = state_q;
    idx_d   = idx_q;
    case (state_q)
      ST_IDLE: begin
        idx_d = '0;
        if (period_tick && en_q) state_d = ST_SCAN;
      end
      ST_SCAN: begin
        for (int i = 0; i < NUM_CH; i++) begin
          if (idx_q == IDX_W'(i)) begin
            live_d[i] = ramp_step(live_q[i], tgt_q[i], step_q);
            upd_d[i]  = (live_d[i] != live_q[i]);
          end
        end
        if (idx_q == LAST_IDX) begin
          state_d = ST_IDLE;
          idx_d   = '0;
        end else begin
          idx_d = idx_q + IDX_W'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      tgt_q   <= '0;
      live_q  <= '0;
      upd_q   <= '0;
      state_q <= ST_IDLE;
      idx_q   <= '0;
      en_q    <= 1'b0;
      step_q  <= 8'd0;
    end else begin
      tgt_q   <= tgt_d;
      live_q  <= live_d;
      upd_q   <= upd_d;
      state_q <= state_d;
      idx_q   <= idx_d;
      en_q    <= en_d;
      step_q  <= step_d;
    end
  end

  always_comb begin
    for (int i = 0; i < NUM_CH; i++) status[i] = (live_q[i] == tgt_q[i]);
  end

`ifdef PWM_RAMP_IRQ_EN
  logic irqm_q, irqm_d;
  logic chg_q, chg_d;
  logic irq_q, irq_d;
  logic all_eq;
  logic scan_last;

  // Completion is judged on the post-update duties and the post-write targets.
  always_comb begin
    all_eq = 1'b1;
    for (int i = 0; i < NUM_CH; i++) begin
      if (live_d[i] != tgt_d[i]) all_eq = 1'b0;
    end
    scan_last = (state_q == ST_SCAN) && (idx_q == LAST_IDX);
    chg_d     = (state_q == ST_SCAN) ? (chg_q | (|upd_d)) : 1'b0;
    irqm_d    = ctrl_wr ? wr_data[IRQM_BIT] : irqm_q;
    irq_d     = irq_q;
    if (ctrl_wr)                                         irq_d = 1'b0;
    else if (scan_last && (chg_q || (|upd_d)) && all_eq) irq_d = 1'b1;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      irqm_q <= 1'b0;
      chg_q  <= 1'b0;
      irq_q  <= 1'b0;
    end else begin
      irqm_q <= irqm_d;
      chg_q  <= chg_d;
      irq_q  <= irq_d;
    end
  end

  assign irq = irq_q & irqm_q;
`endif

  always_comb begin
    rd_data = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (rd_addr == ADDR_W'(TGT_BASE + i)) rd_data = tgt_q[i];
    end
    if (rd_addr == CTRL_A) begin
      rd_data[EN_BIT]            = en_q;
      rd_data[STEP_MSB:STEP_LSB] = step_q;
`ifdef PWM_RAMP_IRQ_EN
      rd_data[IRQM_BIT]          = irqm_q;
`endif
    end
    if (rd_addr == STAT_A) rd_data[NUM_CH-1:0] = status;
  end

  assign duty_out = live_q;
  assign duty_upd = upd_q;
  assign busy     = (state_q == ST_SCAN);

endmodule

// File: doc/pwm_ramp_ctrl.md
Name: pwm_ramp_ctrl

Overview:
- Memory-mapped controller that owns NUM_CH PWM channels and sequences their duty-cycle updates.
- The processor writes per-channel target duties. The controller ramps each channel's live duty toward its target by a programmable step, once per PWM period.
- Each change is delivered to a PWM core as a stable duty word plus a one-cycle update strobe.
- Sits between the processor I/O bus and the bank of PWM cores; it also provides the shared period timebase.

Parameters:
- NUM_CH, 4, number of PWM channels (1..16; must be < PERIOD).
- PERIOD, 100, last timebase count; period = PERIOD+1 clocks, matching the PWM core's 0..100 counter.
- DUTY_W, 32, width of duty words.
- ADDR_W, 5, register address width.

Ports:
- clock  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- wr_en  in  1  register write strobe, one cycle.
- wr_addr  in  ADDR_W  write register index.
- wr_data  in  DUTY_W  write data.
- rd_addr  in  ADDR_W  read register index.
- rd_data  out  DUTY_W  combinational read of the addressed register.
- duty_out  out  NUM_CH*DUTY_W  live duty per channel; channel i occupies bits [i*DUTY_W +: DUTY_W].
- duty_upd  out  NUM_CH  per-channel update strobe; drives the PWM core's update input.
- period_tick  out  1  one-cycle pulse when the timebase count equals PERIOD.
- busy  out  1  high while the FSM is in SCAN.

Behaviour:
- Register map:
  - addr 0..NUM_CH-1: target duty. A write clamps to PERIOD if wr_data > PERIOD.
  - addr NUM_CH: CTRL. bit0 = enable; bits[15:8] = step (0 means jump directly to target).
  - addr NUM_CH+1: STATUS, read-only. bit i = channel i live duty equals its target.
  - Writes to undefined addresses are ignored. Reads of undefined addresses return 0.
- Reset (async, reset=0):
  - Timebase count=0; all targets, live duties and CTRL = 0.
  - duty_upd=0, period_tick=0, busy=0, FSM=IDLE.
  - Reset asserted mid-SCAN aborts the scan; no partial strobes are issued after release.
- Timebase: the count increments every clock and wraps PERIOD -> 0. period_tick is registered and high in the cycle where count==PERIOD. The timebase runs regardless of enable.
- FSM states: IDLE, SCAN.
  - IDLE -> SCAN on period_tick when enable=1; index=0.
  - In SCAN, channel[index] is processed each cycle:
    - if live<target: live=min(live+step, target)
    - if live>target: live=max(live-step, target)
    - step=0: live=target.
  - Arithmetic is done in DUTY_W+1 bits; no wrap-around.
  - SCAN -> IDLE after index NUM_CH-1. The scan takes NUM_CH cycles.
- Strobe timing: if a channel's live duty changed, duty_out[i] updates at the end of its scan cycle. duty_upd[i] pulses high for exactly one cycle, the cycle after. Unchanged channels get no strobe.
- A target write during SCAN:
  - is used this period if that channel's index has not yet been processed;
  - otherwise it is used next period.
- Simultaneous write and process of the same channel in the same cycle: processing uses the old target; the new target is stored.
- enable=0: live duties hold, no strobes, and the FSM stays IDLE. Clearing enable during SCAN lets the current scan complete.
- A period_tick while busy cannot occur, because NUM_CH < PERIOD. Any such tick is ignored.

Optional Feature:
- PWM_RAMP_IRQ_EN defined:
  - adds output port irq (1 bit), a level signal.
  - irq sets at the end of a SCAN in which at least one channel changed and, afterwards, all live duties equal their targets.
  - irq clears on any write to CTRL or on reset.
  - CTRL bit1 = irq mask; irq is gated by the mask.
- Undefined: the irq port and CTRL bit1 are absent; bit1 reads as 0.

Decomposition:
- Package pwm_ramp_pkg:
  - FSM state enum (IDLE, SCAN).
  - Register offset constants: TGT_BASE=0; CTRL_OFS and STAT_OFS as functions of NUM_CH.
  - CTRL bit-position constants: EN_BIT=0, IRQM_BIT=1, STEP_LSB=8, STEP_MSB=15.
- Sub-module pwm_timebase: count 0..PERIOD plus the period_tick output. It is reusable by the PWM cores.

Test Plan:
- Reset release, enable=0, run 300 cycles -> duty_out all 0; duty_upd never set; period_tick every 101 cycles.
- CTRL: enable=1, step=10; target0=35 -> live0 follows 10, 20, 30, 35 on successive ticks; one duty_upd[0] pulse per tick; STATUS bit0=1 after the 4th tick.
- target1=250 -> stored and read back as 100. Then step=0 -> duty_out1 jumps 0->100 in the first scan; single strobe.
- Ramp down:
  - live2=80, step=30, target2=5 -> live2 goes 50, 20, 5.
  - Write target2 during SCAN at index 3 (channel already processed) -> it applies on the next tick.
- Assert reset mid-SCAN at index 1 -> all outputs 0 immediately; busy=0; no strobes after reset release.
- With PWM_RAMP_IRQ_EN: mask=1, target3=20, step=20 -> irq=1 after the first scan; a CTRL write clears it. With mask=0, irq stays 0.
